// File: rtl/ofs_plat_avalon_mem_burst_splitter.sv
// ofs_plat_avalon_mem_burst_splitter
//
// Request-side stage that sits directly upstream of the Avalon memory skid
// buffer. Source bursts longer than MAX_BURST are split into legal sink
// bursts. With NATURAL_ALIGN set, no sink burst crosses a MAX_BURST-aligned
// address boundary. The forward path is combinational (zero added latency);
// only the split progress is held in registers. Read responses come back in
// order and sum to the original burst, so they bypass this block. Write
// responses are not supported.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   src_*               source-side Avalon request (address, burstcount,
//                       read/write, writedata, byteenable, waitrequest out)
//   sink_*              sink-side Avalon request (address, burstcount,
//                       read/write, writedata, byteenable, waitrequest in)
//
// While reset is high the sink sees no request and the source is stalled.
// A burst in flight when reset asserts is abandoned; the sink must be reset
// along with this block.

module ofs_plat_avalon_mem_burst_splitter #(
  parameter int ADDR_WIDTH           = 32,
  parameter int DATA_WIDTH           = 512,
  parameter int SRC_BURST_CNT_WIDTH  = 7,
  parameter int SINK_BURST_CNT_WIDTH = 3,
  parameter int MAX_BURST            = 4,
  parameter int NATURAL_ALIGN        = 1
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic [ADDR_WIDTH-1:0]           src_address,
  input  logic [SRC_BURST_CNT_WIDTH-1:0]  src_burstcount,
  input  logic                            src_read,
  input  logic                            src_write,
  input  logic [DATA_WIDTH-1:0]           src_writedata,
  input  logic [DATA_WIDTH/8-1:0]         src_byteenable,
  output logic                            src_waitrequest,

  output logic [ADDR_WIDTH-1:0]           sink_address,
  output logic [SINK_BURST_CNT_WIDTH-1:0] sink_burstcount,
  output logic                            sink_read,
  output logic                            sink_write,
  output logic [DATA_WIDTH-1:0]           sink_writedata,
  output logic [DATA_WIDTH/8-1:0]         sink_byteenable,
  input  logic                            sink_waitrequest
);

  localparam int AW = ADDR_WIDTH;
  localparam int SW = SRC_BURST_CNT_WIDTH;
  localparam int KW = SINK_BURST_CNT_WIDTH;
  localparam int CW = SRC_BURST_CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_SPLIT,
    WR_BURST
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [SW-1:0]   rem_q, rem_d;
  logic [KW-1:0]   sub_rem_q, sub_rem_d;
  // Address/burstcount of the current write sub-burst, replayed on its
  // non-leading beats so the sink bus stays steady.
  logic [AW-1:0]   hold_addr_q, hold_addr_d;
  logic [KW-1:0]   hold_bc_q, hold_bc_d;

  // Length of the next sink burst starting at a with r beats remaining.
  function automatic logic [KW-1:0] burst_len(input logic [AW-1:0] a,
                                              input logic [SW-1:0] r);
    logic [AW-1:0] off;
    logic [CW-1:0] room;
    logic [CW-1:0] req;
    off  = (NATURAL_ALIGN != 0) ? (a & AW'(MAX_BURST - 1)) : '0;
    room = CW'(MAX_BURST) - CW'(off);
    req  = {1'b0, r};
    return KW'((req < room) ? req : room);
  endfunction

  logic [KW-1:0] idle_len;
  logic [KW-1:0] cur_len;
  logic          idle_fits;
  logic          cur_final;
  logic          wr_lead;

  assign idle_len  = burst_len(src_address, src_burstcount);
  assign cur_len   = burst_len(cur_addr_q, rem_q);
  assign idle_fits = (SW'(idle_len) == src_burstcount);
  assign cur_final = (SW'(cur_len) == rem_q);
  assign wr_lead   = (sub_rem_q == '0);

  assign sink_writedata  = src_writedata;
  assign sink_byteenable = src_byteenable;

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    rem_d           = rem_q;
    sub_rem_d       = sub_rem_q;
    hold_addr_d     = hold_addr_q;
    hold_bc_d       = hold_bc_q;
    sink_read       = 1'b0;
    sink_write      = 1'b0;
    sink_address    = src_address;
    sink_burstcount = idle_len;
    src_waitrequest = sink_waitrequest;

    unique case (state_q)
      IDLE: begin
        if (src_read) begin
          sink_read = 1'b1;
          if (!idle_fits) begin
            // Source command stays pending until the final sub-burst.
            src_waitrequest = 1'b1;
            if (!sink_waitrequest) begin
              state_d    = RD_SPLIT;
              cur_addr_d = src_address + AW'(idle_len);
              rem_d      = src_burstcount - SW'(idle_len);
            end
          end
        end else if (src_write) begin
          sink_write = 1'b1;
          if (!sink_waitrequest && (src_burstcount != SW'(1))) begin
            state_d     = WR_BURST;
            rem_d       = src_burstcount - SW'(1);
            sub_rem_d   = idle_len - KW'(1);
            cur_addr_d  = src_address + AW'(1);
            hold_addr_d = src_address;
            hold_bc_d   = idle_len;
          end
        end
      end

      RD_SPLIT: begin
        sink_read       = 1'b1;
        sink_address    = cur_addr_q;
        sink_burstcount = cur_len;
        src_waitrequest = cur_final ? sink_waitrequest : 1'b1;
        if (!sink_waitrequest) begin
          if (cur_final) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            cur_addr_d = cur_addr_q + AW'(cur_len);
            rem_d      = rem_q - SW'(cur_len);
          end
        end
      end

      WR_BURST: begin
        sink_write      = src_write;
        sink_address    = wr_lead ? cur_addr_q : hold_addr_q;
        sink_burstcount = wr_lead ? cur_len : hold_bc_q;
        if (src_write && !sink_waitrequest) begin
          rem_d      = rem_q - SW'(1);
          cur_addr_d = cur_addr_q + AW'(1);
          if (wr_lead) begin
            sub_rem_d   = cur_len - KW'(1);
            hold_addr_d = cur_addr_q;
            hold_bc_d   = cur_len;
          end else begin
            sub_rem_d = sub_rem_q - KW'(1);
          end
          if (rem_q == SW'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      sink_read       = 1'b0;
      sink_write      = 1'b0;
      src_waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      rem_q       <= '0;
      sub_rem_q   <= '0;
      hold_addr_q <= '0;
      hold_bc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_q       <= rem_d;
      sub_rem_q   <= sub_rem_d;
      hold_addr_q <= hold_addr_d;
      hold_bc_q   <= hold_bc_d;
    end
  end

endmodule
